instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 64'h0, giving the PC value loaded on reset.
REQ-002 The module SHALL have parameter ADDR_W, default 64, giving the PC and address width.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port imem_req, output, 1 bit: instruction-memory read request.
REQ-006 Port imem_addr, output, ADDR_W bits: read address; it SHALL equal pc_out.
REQ-007 Port imem_ack, input, 1 bit: one-cycle pulse; imem_rdata is valid in the same cycle.
REQ-008 Port imem_rdata, input, 32 bits: fetched instruction word.
REQ-009 Port instruction, output, 32 bits: registered instruction delivered to control/decode.
REQ-010 Port pc_out, output, ADDR_W bits: address of the current instruction.
REQ-011 Port instr_valid, output, 1 bit: instruction is valid for the consumer.
REQ-012 Port instr_ready, input, 1 bit: consumer accepts the instruction.
REQ-013 Port resolve_valid, input, 1 bit: one-cycle pulse; branch, unconditional_branch and alu_zero are valid.
REQ-014 Ports branch, unconditional_branch and alu_zero, inputs, 1 bit each: control and ALU outcome for the current instruction.

Function
REQ-015 The FSM SHALL have four states: FETCH, HOLD, RESOLVE and UPDATE.
REQ-016 In FETCH, imem_req SHALL be 1; on imem_ack it SHALL capture imem_rdata into instruction and go to HOLD.
REQ-017 In FETCH, with no ack, the FSM SHALL stay in FETCH with imem_req held high for an unbounded number of cycles.
REQ-018 imem_ack SHALL be ignored in every state except FETCH.
REQ-019 In HOLD, instr_valid SHALL be 1 and instruction SHALL be stable; on instr_valid & instr_ready the FSM SHALL go to RESOLVE.
REQ-020 instr_valid SHALL first rise in the cycle after the ack; there is no combinational path from imem_ack to instr_valid.
REQ-021 In RESOLVE, instr_valid SHALL be 0; on resolve_valid the FSM SHALL register taken = unconditional_branch | (branch & alu_zero) and go to UPDATE.
REQ-022 resolve_valid SHALL be ignored in every state except RESOLVE.
REQ-023 Offset rules: when instruction[31:26]==6'b000101 (B), offset = sign-extend(instruction[25:0]); otherwise offset = sign-extend(instruction[23:5]) (CB format).
REQ-024 In UPDATE, pc_out SHALL become pc_out + (offset << 2) if taken, else pc_out + 4; the FSM SHALL then go to FETCH.
REQ-025 PC arithmetic SHALL be modulo 2^ADDR_W; wrap-around is silent.
REQ-026 Latency: at least 1 cycle from the ack-capture edge to instr_valid.
REQ-027 Latency: 1 cycle from resolve_valid to the pc_out update.
REQ-028 Latency: 1 further cycle from the pc_out update to imem_req.
REQ-029 At most one instruction SHALL be outstanding at a time (non-pipelined).
REQ-030 imem_req and instr_valid SHALL never both be 1 in the same cycle.

Reset
REQ-031 While reset is 1: pc_out=RESET_PC, instruction=32'h0, instr_valid=0, imem_req=0, and the FSM is in FETCH.
REQ-032 imem_req SHALL assert in the first cycle after reset deasserts.
REQ-033 Reset asserted mid-fetch SHALL abort the fetch, and a late ack SHALL be discarded.
REQ-034 Reset asserted in HOLD or RESOLVE SHALL drop instr_valid immediately (asynchronously).

Configuration
REQ-035 With FETCH_CNT_EN defined, output fetch_count (32 bits) SHALL reset to 0 and increment by 1 on each instr_valid & instr_ready handshake, wrapping from 32'hFFFFFFFF to 0.
REQ-036 Without FETCH_CNT_EN, the fetch_count port and its counter logic SHALL be absent; all other behaviour is identical.

Verification
REQ-037 Reset, then ack with 32'hF84402C9 after 0 wait cycles -> imem_addr=0x0, instruction=32'hF84402C9 with instr_valid=1 next cycle; resolve not taken -> pc_out=0x4.
REQ-038 At pc_out=0x10, instruction 32'h14000040 (B 64), resolve unconditional_branch=1 -> pc_out=0x110.
REQ-039 At pc_out=0x20, instruction 32'hB4FFFF6B (CBZ -5), branch=1, alu_zero=1 -> pc_out=0x0C; same case with alu_zero=0 -> pc_out=0x24.
REQ-040 Ack delayed 3 cycles and instr_ready held low 2 cycles -> imem_req high for exactly 4 cycles, instruction stable throughout HOLD, and stray ack/resolve pulses outside FETCH/RESOLVE have no effect.
REQ-041 Reset asserted while in FETCH with a pending ack -> pc_out=RESET_PC, the late ack is discarded, and a clean refetch occurs from 0x0.
REQ-042 With FETCH_CNT_EN defined, 10 handshakes -> fetch_count=10; with pc_out=64'hFFFFFFFFFFFFFFFC and not taken -> pc_out wraps to 0x0.

Source files
------------

// File: rtl/instr_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instr_fetch : non-pipelined instruction fetch / PC update FSM            |
// | Optional fetch_count handshake counter enabled by macro FETCH_CNT_EN.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module instr_fetch #(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instruction,
    output logic [ADDR_W-1:0] pc_out,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              resolve_valid,
    input  logic              branch,
    input  logic              unconditional_branch,
    input  logic              alu_zero
`ifdef FETCH_CNT_EN
    ,
    output logic [31:0]       fetch_count
`endif
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        RESOLVE = 2'd2,
        UPDATE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_instr;
    logic              r_taken;
    logic [ADDR_W-1:0] w_offset;
    logic [ADDR_W-1:0] w_step;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            FETCH:   if (imem_ack)      w_next_state = HOLD;
            HOLD:    if (instr_ready)   w_next_state = RESOLVE;
            RESOLVE: if (resolve_valid) w_next_state = UPDATE;
            UPDATE:                     w_next_state = FETCH;
            default:                    w_next_state = FETCH;
        endcase
    end

    // B format carries a 26-bit word offset, CB format a 19-bit one at [23:5]
    always_comb begin
        w_offset = ADDR_W'($signed(r_instr[23:5]));
        if (r_instr[31:26] == 6'b000101) begin
            w_offset = ADDR_W'($signed(r_instr[25:0]));
        end
        w_step = r_taken ? (w_offset << 2) : ADDR_W'(4);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc    <= RESET_PC;
            r_instr <= 32'h0;
            r_taken <= 1'b0;
        end else begin
            if (r_state == FETCH && imem_ack) begin
                r_instr <= imem_rdata;
            end
            if (r_state == RESOLVE && resolve_valid) begin
                r_taken <= unconditional_branch | (branch & alu_zero);
            end
            if (r_state == UPDATE) begin
                r_pc <= r_pc + w_step;
            end
        end
    end

`ifdef FETCH_CNT_EN
    logic [31:0] r_fetch_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_count <= 32'h0;
        end else if (r_state == HOLD && instr_ready) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign fetch_count = r_fetch_count;
`endif

    // Reset gates the request so it is low while reset is held
    assign imem_req    = (r_state == FETCH) & ~reset;
    assign instr_valid = (r_state == HOLD);
    assign imem_addr   = r_pc;
    assign pc_out      = r_pc;
    assign instruction = r_instr;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_instr_fetch : directed self-checking bench for instr_fetch            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_instr_fetch;

    localparam int          ADDR_W   = 64;
    localparam logic [63:0] RESET_PC = 64'h0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        instr_ready = 1'b0;
    logic        resolve_valid = 1'b0;
    logic        branch = 1'b0;
    logic        unconditional_branch = 1'b0;
    logic        alu_zero = 1'b0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] instruction;
    logic [63:0] pc_out;
    logic        instr_valid;
`ifdef FETCH_CNT_EN
    logic [31:0] fetch_count;
`endif

    instr_fetch #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
        .clk                  (clk),
        .reset                (reset),
        .imem_req             (imem_req),
        .imem_addr            (imem_addr),
        .imem_ack             (imem_ack),
        .imem_rdata           (imem_rdata),
        .instruction          (instruction),
        .pc_out               (pc_out),
        .instr_valid          (instr_valid),
        .instr_ready          (instr_ready),
        .resolve_valid        (resolve_valid),
        .branch               (branch),
        .unconditional_branch (unconditional_branch),
        .alu_zero             (alu_zero)
`ifdef FETCH_CNT_EN
        ,
        .fetch_count          (fetch_count)
`endif
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    int          req_cycles = 0;
    int          handshakes = 0;
    logic        checking = 1'b0;
    logic [63:0] exp_pc = RESET_PC;
    logic [31:0] exp_instr = 32'h0;
    logic        exp_req = 1'b0;
    logic        exp_valid = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Architectural next-PC: branch target in bytes is the signed word offset times four
    function automatic logic [63:0] next_pc(input logic [63:0] pc, input logic [31:0] ins, input bit taken);
        longint      o;
        logic [63:0] d;
        if (!taken) return pc + 64'd4;
        if (ins[31:26] == 6'b000101) begin
            o = longint'(ins[25:0]);
            if (o >= (longint'(1) << 25)) o = o - (longint'(1) << 26);
        end else begin
            o = longint'(ins[23:5]);
            if (o >= (longint'(1) << 18)) o = o - (longint'(1) << 19);
        end
        d = 64'(o * 4);
        return pc + d;
    endfunction

    always @(negedge clk) begin
        if (checking && !reset) begin
            check("req",    64'(imem_req),    64'(exp_req));
            check("valid",  64'(instr_valid), 64'(exp_valid));
            check("pc",     pc_out,           exp_pc);
            check("addr",   imem_addr,        exp_pc);
            check("instr",  64'(instruction), 64'(exp_instr));
            check("excl",   64'(imem_req & instr_valid), 64'h0);
            if (imem_req) req_cycles++;
            if (instr_valid && instr_ready) handshakes++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [31:0] word, input int waits, input bit stray);
        for (int i = 0; i < waits; i++) begin
            if (stray && i == 0) begin
                resolve_valid = 1'b1;
                unconditional_branch = 1'b1;
            end
            tick();
            resolve_valid = 1'b0;
            unconditional_branch = 1'b0;
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEADBEEF;
        exp_instr  = word;
        exp_req    = 1'b0;
        exp_valid  = 1'b1;
    endtask

    task automatic do_hold(input int ready_delay, input bit stray);
        for (int i = 0; i < ready_delay; i++) begin
            if (stray && i == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = 32'h12345678;
            end
            if (stray && i == 1) begin
                resolve_valid = 1'b1;
                unconditional_branch = 1'b1;
            end
            tick();
            imem_ack = 1'b0;
            resolve_valid = 1'b0;
            unconditional_branch = 1'b0;
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        exp_valid   = 1'b0;
    endtask

    task automatic do_resolve(input int waits, input bit b, input bit u, input bit z, input bit stray);
        for (int i = 0; i < waits; i++) begin
            if (stray) begin
                imem_ack   = 1'b1;
                imem_rdata = 32'hA5A5A5A5;
            end
            tick();
            imem_ack = 1'b0;
        end
        resolve_valid = 1'b1;
        branch = b;
        unconditional_branch = u;
        alu_zero = z;
        tick();
        resolve_valid = 1'b0;
        branch = 1'b0;
        unconditional_branch = 1'b0;
        alu_zero = 1'b0;
        tick();
        exp_pc  = next_pc(exp_pc, exp_instr, u | (b & z));
        exp_req = 1'b1;
    endtask

    task automatic run(input logic [31:0] word, input bit b, input bit u, input bit z);
        do_fetch(word, 0, 1'b0);
        do_hold(0, 1'b0);
        do_resolve(0, b, u, z, 1'b0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #2;
        check("rst_pc",    pc_out,              RESET_PC);
        check("rst_instr", 64'(instruction),    64'h0);
        check("rst_valid", 64'(instr_valid),    64'h0);
        check("rst_req",   64'(imem_req),       64'h0);
        tick();
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        reset      = 1'b0;
        exp_pc     = RESET_PC;
        exp_instr  = 32'h0;
        exp_req    = 1'b1;
        exp_valid  = 1'b0;
        handshakes = 0;
        #1;
        check("req_after_rst", 64'(imem_req), 64'h1);
    endtask

    initial begin
        tick();
        apply_reset();
        checking = 1'b1;

        check("t1_addr", imem_addr, 64'h0);
        do_fetch(32'hF84402C9, 0, 1'b0);
        check("t1_instr", 64'(instruction), 64'hF84402C9);
        check("t1_valid", 64'(instr_valid), 64'h1);
        do_hold(0, 1'b0);
        do_resolve(0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t1_pc", pc_out, 64'h4);

        for (int i = 0; i < 3; i++) run(32'h00000000, 1'b0, 1'b0, 1'b0);
        check("seq_pc", pc_out, 64'h10);
        run(32'h14000040, 1'b0, 1'b1, 1'b0);
        check("b64_pc", pc_out, 64'h110);
        run(32'h17FFFFC4, 1'b0, 1'b1, 1'b0);
        check("bback_pc", pc_out, 64'h20);
        run(32'hB4FFFF6B, 1'b1, 1'b0, 1'b1);
        check("cbz_taken_pc", pc_out, 64'h0C);
        run(32'h14000005, 1'b0, 1'b1, 1'b0);
        run(32'hB4FFFF6B, 1'b1, 1'b0, 1'b0);
        check("cbz_not_taken_pc", pc_out, 64'h24);

        req_cycles = 0;
        do_fetch(32'h00000000, 3, 1'b1);
        check("req_cycles", 64'(req_cycles), 64'd4);
        do_hold(2, 1'b1);
        check("hold_instr", 64'(instruction), 64'h0);
        do_resolve(1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("stray_pc", pc_out, 64'h28);

        run(32'h17FFFFF5, 1'b0, 1'b1, 1'b0);
        check("near_top_pc", pc_out, 64'hFFFFFFFFFFFFFFFC);
        run(32'hF84402C9, 1'b1, 1'b0, 1'b0);
        check("wrap_pc", pc_out, 64'h0);
        run(32'h14000040, 1'b0, 1'b0, 1'b1);
        check("b_no_uncond_pc", pc_out, 64'h4);

        tick();
        imem_ack   = 1'b1;
        imem_rdata = 32'hCAFEF00D;
        apply_reset();
        check("late_ack_instr", 64'(instruction), 64'h0);
        do_fetch(32'hF84402C9, 1, 1'b0);
        do_hold(0, 1'b0);
        do_resolve(0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("refetch_pc", pc_out, 64'h4);

        do_fetch(32'h11111111, 0, 1'b0);
        apply_reset();

        for (int i = 0; i < 10; i++) run(32'h00000000, 1'b0, 1'b0, 1'b0);
        check("ten_pc", pc_out, 64'h28);
        check("ten_handshakes", 64'(handshakes), 64'd10);
`ifdef FETCH_CNT_EN
        check("fetch_count", 64'(fetch_count), 64'd10);
`endif

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running, want finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
